// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM stage with ready/rvalid data bus; `define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        bus_err,
  output logic        misalign_exc
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic        rw_q;
  logic        is_mem;
  logic        mis;
  logic        timeout;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] byte_sh;
  logic [15:0] half;
  logic [31:0] ld_data;
  assign mem_stall = state != IDLE;
  always_comb begin
    is_mem  = ex_mem_read | ex_mem_write;
    mis     = TRAP & (ex_funct3[1:0] == 2'b01 ? ex_alu_out[0] :
                      ex_funct3[1:0] != 2'b00 && ex_alu_out[1:0] != 2'b00);
    st_strb = ex_funct3[1:0] == 2'b00 ? 4'b0001 << ex_alu_out[1:0] :
              ex_funct3[1:0] == 2'b01 ? 4'b0011 << {ex_alu_out[1], 1'b0} : 4'hf;
    st_data = ex_funct3[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
              ex_funct3[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
    byte_sh = dmem_rdata >> {lane_q, 3'b000};
    half    = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_sh[7]}}, byte_sh[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half[15]}}, half} : dmem_rdata;
    timeout = cnt + 8'd1 == MW;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lane_q       <= '0;
      f3_q         <= '0;
      rw_q         <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      bus_err      <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          wb_rd <= ex_rd;
          if (!is_mem || mis) begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_alu_out;
            wb_reg_write <= ex_reg_write & !is_mem;
            misalign_exc <= is_mem;
          end else begin
            state      <= REQ;
            cnt        <= '0;
            lane_q     <= ex_alu_out[1:0];
            f3_q       <= ex_funct3;
            rw_q       <= ex_reg_write;
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= {ex_alu_out[31:2], 2'b00};
            dmem_wdata <= ex_mem_write ? st_data : '0;
            dmem_wstrb <= ex_mem_write ? st_strb : 4'h0;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? IDLE : RESP;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
            end
          end else if (timeout) begin
            dmem_req     <= 1'b0;
            state        <= IDLE;
            bus_err      <= 1'b1;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
          end
        end
        RESP: begin
          cnt <= cnt + 8'd1;
          if (dmem_rvalid || timeout) begin
            state        <= IDLE;
            wb_valid     <= 1'b1;
            bus_err      <= !dmem_rvalid;
            wb_reg_write <= dmem_rvalid & rw_q;
            if (dmem_rvalid) wb_data <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
